pcpi_approx_mul32: RTL and testbench
====================================

Name: pcpi_approx_mul32

Overview:
- PicoRV32 PCPI co-processor that executes RV32M MUL/MULH/MULHSU/MULHU using one shared x16_approx_mul instance, iterated over four 16x16 partial products.
- Sits between the core's PCPI bus and the approximate 16-bit multiplier.
- Sequences the operand halves into the multiplier, accumulates the shifted 32-bit partial products into a 64-bit sum, applies the sign correction and returns the selected word.

Parameters:
- N16, 0, approximation setting passed to x16_approx_mul (its adder stage)
- N8, 0, approximation setting passed to x16_approx_mul (8-bit multiplier level)
- N4, 0, approximation setting passed to x16_approx_mul (4-bit multiplier level)

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- pcpi_valid  in  1  core presents an instruction
- pcpi_insn  in  32  instruction word
- pcpi_rs1  in  32  operand A
- pcpi_rs2  in  32  operand B
- pcpi_wr  out  1  result write-back strobe
- pcpi_rd  out  32  result
- pcpi_wait  out  1  co-processor has claimed the instruction and is busy
- pcpi_ready  out  1  result valid, one-cycle pulse

Behaviour:
- Decode (match): opcode[6:0]=0110011, funct7=0000001, funct3 in {000 MUL, 001 MULH, 010 MULHSU, 011 MULHU}. funct3 1xx (div/rem) is not matched.
- States: IDLE, CALC (2-bit counter k=0..3), DONE.
- IDLE: if pcpi_valid & match & !cool, then at the edge:
  - latch magA = |rs1| if rs1 is signed and negative, else rs1;
  - latch magB the same way for rs2;
  - latch neg = signA ^ signB and the op;
  - clear acc[63:0], k=0, go to CALC.
- Signedness:
  - MULH: rs1 and rs2 signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU and MUL: both unsigned; neg=0.
  - |0x80000000| is 0x80000000, taken as an unsigned 32-bit magnitude.
- CALC, per k:
  - k=0: multiplier inputs aL,bL, shift 0
  - k=1: aL,bH, shift 16
  - k=2: aH,bL, shift 16
  - k=3: aH,bH, shift 32
  - Each edge: acc += zero-extended product << shift, using an exact 64-bit add; k increments.
  - At k=3 the edge also loads pcpi_rd:
    - P = neg ? (~(acc+pp3)+1) : (acc+pp3), 64-bit;
    - pcpi_rd = P[31:0] for MUL, else P[63:32];
    - go to DONE.
- DONE: pcpi_ready=1 and pcpi_wr=1 for exactly one cycle. Next state IDLE with cool=1 for that one IDLE cycle (blocks re-accept while the core's pcpi_valid is still dropping).
- Latency: accept edge at cycle T, CALC for T+1..T+4, pcpi_ready high in T+5 only.
- pcpi_wait:
  - combinational: (IDLE & pcpi_valid & match & !cool) | CALC;
  - high T..T+4, low in DONE.
- pcpi_rd holds its value until the next load. pcpi_wr and pcpi_ready are 0 outside DONE.
- Abort: pcpi_valid low during CALC → IDLE next edge, no ready, acc discarded.
- Unmatched instruction: no wait, no ready, state stays IDLE.
- Reset (any state, including mid-CALC) → IDLE, k=0, acc=0, cool=0, pcpi_rd=0, pcpi_wr=0, pcpi_ready=0, pcpi_wait=0.
- Approximation error comes only from the x16_approx_mul instance. With N16=N8=N4=0 the results are exact RV32M results.

Decomposition:
- Shared include approx_mul_defs.vh: opcode/funct7/funct3 constants, state encodings.
- Sub-module: one x16_approx_mul #(N16,N8,N4) instance, inputs muxed by k.
- All control, abs/negate and accumulation logic stays in pcpi_approx_mul32.

Test Plan:
- MUL, rs1=3, rs2=5 (default params) → wait high T..T+4, ready/wr only at T+5, pcpi_rd=0x0000000F.
- MULHU, rs1=rs2=0xFFFFFFFF → pcpi_rd=0xFFFFFFFE; the same operands with MUL → 0x00000001.
- MULH:
  - 0x80000000 x 0x80000000 → 0x40000000;
  - 0xFFFFFFFF x 0xFFFFFFFF → 0x00000000.
- MULHSU, rs1=0xFFFFFFFE, rs2=3 → pcpi_rd=0xFFFFFFFF. MULH 0xFFFFFFFE x 0xFFFFFFFE → 0x00000000.
- DIV insn (funct3=100) or funct7=0 with valid held 10 cycles → wait, ready and wr stay 0.
- Control corner cases:
  - reset asserted at T+2 of a MUL → all outputs 0 next cycle, no ready;
  - pcpi_valid dropped at T+3 → IDLE, no ready;
  - valid held through DONE → no second accept in T+6.

Source files
------------

// File: rtl/pcpi_approx_mul32_pkg.sv
// Shared decode constants, FSM states and op encoding for the PCPI approximate multiplier.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pcpi_approx_mul32_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] F7_MULDIV  = 7'b0000001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // funct3[1:0] of the four accepted RV32M multiply ops
  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } op_t;

  // True for MUL/MULH/MULHSU/MULHU; div/rem (funct3 1xx) are left to another unit
  function automatic logic is_mul(input logic [6:0] funct7, input logic [2:0] funct3,
                                  input logic [6:0] opcode);
    return (opcode == OPC_OP) && (funct7 == F7_MULDIV) && !funct3[2];
  endfunction

endpackage

// File: rtl/pcpi_if.sv
// PicoRV32 PCPI bus between the core (master) and a co-processor (slave).
// Latency: n/a (wires only).
// Backpressure: slave holds pcpi_wait while busy; core holds pcpi_valid until ready.
interface pcpi_if;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn;
  logic [31:0] pcpi_rs1;
  logic [31:0] pcpi_rs2;
  logic        pcpi_wr;
  logic [31:0] pcpi_rd;
  logic        pcpi_wait;
  logic        pcpi_ready;

  modport master (
    output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
    input  pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready
  );

  modport slave (
    input  pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
    output pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready
  );
endinterface

// File: rtl/pcpi_approx_mul32_x16.sv
// Approximate 16x16 unsigned multiplier built from 8x8 blocks of 4x4 blocks.
// Latency: purely combinational.
// Backpressure: none.
module x16_approx_mul #(
  parameter int N16 = 0,  // low result bits summed with an OR instead of a carry chain
  parameter int N8  = 0,  // low bits dropped from each 8x8 partial product
  parameter int N4  = 0   // low bits dropped from each 4x4 partial product
) (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] p
);

  localparam logic [7:0]  LO4  = 8'((16'd1 << N4) - 16'd1);
  localparam logic [15:0] LO8  = 16'((32'd1 << N8) - 32'd1);
  localparam logic [31:0] LO16 = 32'((64'd1 << N16) - 64'd1);

  function automatic logic [7:0] mul4(input logic [3:0] x, input logic [3:0] y);
    logic [7:0] r;
    r = {4'b0, x} * {4'b0, y};
    return r & ~LO4;
  endfunction

  function automatic logic [15:0] mul8(input logic [7:0] x, input logic [7:0] y);
    logic [15:0] s;
    s = {8'b0, mul4(x[3:0], y[3:0])}
      + ({8'b0, mul4(x[3:0], y[7:4])} << 4)
      + ({8'b0, mul4(x[7:4], y[3:0])} << 4)
      + ({8'b0, mul4(x[7:4], y[7:4])} << 8);
    return s & ~LO8;
  endfunction

  logic [31:0] t0, t1, t2, t3;

  // Combine the four 8x8 products; the low N16 bits use a carry-free OR
  always_comb begin
    t0 = {16'b0, mul8(a[7:0],  b[7:0])};
    t1 = {16'b0, mul8(a[7:0],  b[15:8])} << 8;
    t2 = {16'b0, mul8(a[15:8], b[7:0])}  << 8;
    t3 = {16'b0, mul8(a[15:8], b[15:8])} << 16;
    p  = ((t0 & ~LO16) + (t1 & ~LO16) + (t2 & ~LO16) + (t3 & ~LO16))
       | ((t0 | t1 | t2 | t3) & LO16);
  end

endmodule

// File: rtl/pcpi_approx_mul32.sv
// PCPI RV32M MUL/MULH/MULHSU/MULHU using one 16x16 multiplier iterated over four partial products.
// Latency: accept edge T, result with a one-cycle ready/wr pulse in cycle T+5.
// Backpressure: pcpi_wait held while busy; dropping pcpi_valid mid-calculation aborts.
module pcpi_approx_mul32
  import pcpi_approx_mul32_pkg::*;
#(
  parameter int N16 = 0,
  parameter int N8  = 0,
  parameter int N4  = 0
) (
  input  logic  clk,
  input  logic  reset,
  pcpi_if.slave pcpi
);

  state_t      state, state_nxt;
  logic [1:0]  k;
  logic [63:0] acc;
  logic [31:0] mag_a, mag_b;
  logic        neg;
  op_t         op;
  logic        cool;
  logic [31:0] rd_q;

  logic        match, accept, sgn_a, sgn_b;
  op_t         insn_op;
  logic [15:0] mul_a, mul_b;
  logic [31:0] pp;
  logic [63:0] pp_shifted, acc_sum, prod;
  logic        unused_insn_bits;

  assign unused_insn_bits = ^{pcpi.pcpi_insn[24:15], pcpi.pcpi_insn[11:7]};

  // Decode the instruction and the signedness of each operand
  always_comb begin
    match   = is_mul(pcpi.pcpi_insn[31:25], pcpi.pcpi_insn[14:12], pcpi.pcpi_insn[6:0]);
    insn_op = op_t'(pcpi.pcpi_insn[13:12]);
    accept  = (state == ST_IDLE) && pcpi.pcpi_valid && match && !cool;
    sgn_a   = ((insn_op == OP_MULH) || (insn_op == OP_MULHSU)) && pcpi.pcpi_rs1[31];
    sgn_b   = (insn_op == OP_MULH) && pcpi.pcpi_rs2[31];
  end

  // Step k picks operand halves: bit1 selects A's half, bit0 selects B's half
  assign mul_a = k[1] ? mag_a[31:16] : mag_a[15:0];
  assign mul_b = k[0] ? mag_b[31:16] : mag_b[15:0];

  x16_approx_mul #(.N16(N16), .N8(N8), .N4(N4)) u_mul (
    .a (mul_a),
    .b (mul_b),
    .p (pp)
  );

  // Align the partial product, accumulate, and sign-correct the final sum
  always_comb begin
    pp_shifted = {32'b0, pp};
    case (k)
      2'd1, 2'd2: pp_shifted = {16'b0, pp, 16'b0};
      2'd3:       pp_shifted = {pp, 32'b0};
      default:    pp_shifted = {32'b0, pp};
    endcase
    acc_sum = acc + pp_shifted;
    prod    = neg ? (~acc_sum + 64'd1) : acc_sum;
  end

  // State register; cool masks the single IDLE cycle after DONE
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cool  <= 1'b0;
    end else begin
      state <= state_nxt;
      cool  <= (state == ST_DONE);
    end
  end

  // Next state: abort on dropped valid, finish after the fourth partial product
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_CALC;
      ST_CALC: begin
        if (!pcpi.pcpi_valid)  state_nxt = ST_IDLE;
        else if (k == 2'd3)    state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Operand capture, accumulation and result register
  always_ff @(posedge clk) begin
    if (reset) begin
      k     <= 2'd0;
      acc   <= 64'd0;
      mag_a <= 32'd0;
      mag_b <= 32'd0;
      neg   <= 1'b0;
      op    <= OP_MUL;
      rd_q  <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: if (accept) begin
          mag_a <= sgn_a ? (32'd0 - pcpi.pcpi_rs1) : pcpi.pcpi_rs1;
          mag_b <= sgn_b ? (32'd0 - pcpi.pcpi_rs2) : pcpi.pcpi_rs2;
          neg   <= sgn_a ^ sgn_b;
          op    <= insn_op;
          acc   <= 64'd0;
          k     <= 2'd0;
        end
        ST_CALC: begin
          if (!pcpi.pcpi_valid) begin
            acc <= 64'd0;
            k   <= 2'd0;
          end else begin
            acc <= acc_sum;
            k   <= k + 2'd1;
            if (k == 2'd3) rd_q <= (op == OP_MUL) ? prod[31:0] : prod[63:32];
          end
        end
        default: ;
      endcase
    end
  end

  assign pcpi.pcpi_wait  = accept || (state == ST_CALC);
  assign pcpi.pcpi_ready = (state == ST_DONE);
  assign pcpi.pcpi_wr    = (state == ST_DONE);
  assign pcpi.pcpi_rd    = rd_q;

endmodule

// File: tb/tb_pcpi_approx_mul32.sv
// Self-checking bench for pcpi_approx_mul32 with exact (default) approximation settings.
// Latency: checks the T..T+5 handshake timing of every transaction.
// Backpressure: exercises abort, reset mid-op and valid held through DONE.
module tb_pcpi_approx_mul32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pcpi_if bus ();

  pcpi_approx_mul32 dut (
    .clk   (clk),
    .reset (reset),
    .pcpi  (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] last_rd = 32'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] make_insn(input logic [6:0] f7, input logic [2:0] f3);
    return {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
  endfunction

  // Arithmetic reference: 65-bit sign/zero-extended operands, full product, word select
  function automatic logic [31:0] ref_mul(input logic [1:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [64:0]  sa, sb;
    logic signed [129:0] full;
    sa = (f3 == 2'b01 || f3 == 2'b10) ? $signed({{33{a[31]}}, a}) : $signed({33'b0, a});
    sb = (f3 == 2'b01)                ? $signed({{33{b[31]}}, b}) : $signed({33'b0, b});
    full = sa * sb;
    return (f3 == 2'b00) ? full[31:0] : full[63:32];
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] insn, input logic [31:0] a,
                       input logic [31:0] b);
    bus.pcpi_valid = v;
    bus.pcpi_insn  = insn;
    bus.pcpi_rs1   = a;
    bus.pcpi_rs2   = b;
  endtask

  // One full transaction, cycle-by-cycle: c=0 is the accept cycle T
  task automatic run_op(input string tag, input logic [1:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input bit hold);
    logic [31:0] exp;
    exp = ref_mul(f3, a, b);
    next_cycle();
    drive(1'b1, make_insn(7'h01, {1'b0, f3}), a, b);
    for (int c = 0; c <= 6; c++) begin
      if (c > 0) begin
        next_cycle();
        if (c == 6 && !hold) bus.pcpi_valid = 1'b0;
      end
      @(negedge clk);
      check($sformatf("%s/wait%0d", tag, c), {31'b0, bus.pcpi_wait}, {31'b0, c <= 4});
      check($sformatf("%s/ready%0d", tag, c), {31'b0, bus.pcpi_ready}, {31'b0, c == 5});
      check($sformatf("%s/wr%0d", tag, c), {31'b0, bus.pcpi_wr}, {31'b0, c == 5});
      if (c >= 5) check($sformatf("%s/rd%0d", tag, c), bus.pcpi_rd, exp);
    end
    next_cycle();
    bus.pcpi_valid = 1'b0;
    last_rd = exp;
  endtask

  logic [31:0] corners [6] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000,
                               32'h7FFF_FFFF, 32'h0000_FFFF};

  function automatic logic [31:0] pick_operand();
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  initial begin
    reset = 1'b1;
    drive(1'b0, 32'd0, 32'd0, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst/wait",  {31'b0, bus.pcpi_wait},  32'd0);
    check("rst/ready", {31'b0, bus.pcpi_ready}, 32'd0);
    check("rst/wr",    {31'b0, bus.pcpi_wr},    32'd0);
    check("rst/rd",    bus.pcpi_rd,             32'd0);
    reset = 1'b0;

    run_op("mul3x5",      2'b00, 32'd3,          32'd5,          1'b0);
    check("mul3x5/val", bus.pcpi_rd, 32'h0000_000F);
    run_op("mulhu_ff",    2'b11, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0);
    check("mulhu_ff/val", bus.pcpi_rd, 32'hFFFF_FFFE);
    run_op("mul_ff",      2'b00, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0);
    check("mul_ff/val", bus.pcpi_rd, 32'h0000_0001);
    run_op("mulh_min",    2'b01, 32'h8000_0000,  32'h8000_0000,  1'b0);
    check("mulh_min/val", bus.pcpi_rd, 32'h4000_0000);
    run_op("mulh_m1",     2'b01, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0);
    check("mulh_m1/val", bus.pcpi_rd, 32'h0000_0000);
    run_op("mulhsu",      2'b10, 32'hFFFF_FFFE,  32'd3,          1'b0);
    check("mulhsu/val", bus.pcpi_rd, 32'hFFFF_FFFF);
    run_op("mulh_m2",     2'b01, 32'hFFFF_FFFE,  32'hFFFF_FFFE,  1'b0);
    check("mulh_m2/val", bus.pcpi_rd, 32'h0000_0000);
    run_op("hold",        2'b00, 32'h1234_5678,  32'h9ABC_DEF0,  1'b1);

    // Unmatched instructions: DIV (funct3=100) and funct7=0, valid held 10 cycles
    for (int u = 0; u < 2; u++) begin
      next_cycle();
      drive(1'b1, (u == 0) ? make_insn(7'h01, 3'b100) : make_insn(7'h00, 3'b000),
            32'd7, 32'd9);
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        check($sformatf("nomatch%0d/wait", u),  {31'b0, bus.pcpi_wait},  32'd0);
        check($sformatf("nomatch%0d/ready", u), {31'b0, bus.pcpi_ready}, 32'd0);
        check($sformatf("nomatch%0d/wr", u),    {31'b0, bus.pcpi_wr},    32'd0);
        if (c < 9) next_cycle();
      end
      next_cycle();
      bus.pcpi_valid = 1'b0;
    end

    // Abort: valid dropped during T+3
    next_cycle();
    drive(1'b1, make_insn(7'h01, 3'b000), 32'd11, 32'd13);
    next_cycle();
    next_cycle();
    next_cycle();
    bus.pcpi_valid = 1'b0;
    @(negedge clk);
    check("abort/wait_t3", {31'b0, bus.pcpi_wait}, 32'd1);
    for (int c = 4; c < 9; c++) begin
      next_cycle();
      @(negedge clk);
      check($sformatf("abort/wait%0d", c),  {31'b0, bus.pcpi_wait},  32'd0);
      check($sformatf("abort/ready%0d", c), {31'b0, bus.pcpi_ready}, 32'd0);
      check($sformatf("abort/rd%0d", c),    bus.pcpi_rd,             last_rd);
    end
    run_op("after_abort", 2'b11, 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0);

    // Reset asserted during T+2 of a MUL
    next_cycle();
    drive(1'b1, make_insn(7'h01, 3'b000), 32'd3, 32'd5);
    next_cycle();
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    check("rstmid/wait_t2", {31'b0, bus.pcpi_wait}, 32'd1);
    next_cycle();
    reset = 1'b0;
    bus.pcpi_valid = 1'b0;
    for (int c = 3; c < 8; c++) begin
      @(negedge clk);
      check($sformatf("rstmid/wait%0d", c),  {31'b0, bus.pcpi_wait},  32'd0);
      check($sformatf("rstmid/ready%0d", c), {31'b0, bus.pcpi_ready}, 32'd0);
      check($sformatf("rstmid/wr%0d", c),    {31'b0, bus.pcpi_wr},    32'd0);
      check($sformatf("rstmid/rd%0d", c),    bus.pcpi_rd,             32'd0);
      next_cycle();
    end

    // Randomized operations against the arithmetic reference
    for (int i = 0; i < 40; i++) begin
      logic [1:0]  f3;
      logic [31:0] a, b;
      f3 = 2'($urandom_range(0, 3));
      a  = pick_operand();
      b  = pick_operand();
      run_op($sformatf("rand%0d", i), f3, a, b, ($urandom_range(0, 1) == 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
